clk_divider_multi: RTL
======================

Name: clk_divider_multi

Overview:
Multi-channel, runtime-programmable successor to the fixed-ratio clk_divider. It generates N_CH independent divided-clock waveforms plus period-start tick pulses, all from one input clock. Divide ratios are reprogrammed through a shadow register that commits only at a period boundary, so outputs never glitch. A global sync input phase-aligns every running channel.

Parameters:
N_CH, 4, number of independent divider channels
DIV_W, 10, width of each divide ratio (max ratio 2^DIV_W-1)
DEFAULT_DIV, 10, active ratio of every channel after reset

Ports:
clk_in  input  1  sole clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
ch_en  input  N_CH  per-channel run enable
div_ratio  input  N_CH*DIV_W  packed ratios; channel i at bits [i*DIV_W +: DIV_W]
div_load  input  N_CH  per-channel load strobe for div_ratio slice
sync  input  1  restart all enabled channels in phase
clk_out  output  N_CH  registered divided waveform
tick  output  N_CH  registered 1-cycle pulse at each period start
pend  output  N_CH  pending ratio not yet committed

Behaviour:
- Reset: every channel: active ratio R=DEFAULT_DIV, cnt=0, pend=0, clk_out=0, tick=0. A reset mid-period aborts the period at once and discards the pending ratio.
- Per-channel state: cnt[DIV_W], active R, pending ratio plus pend flag. Let H=ceil(R/2).
- Next-count rule for an enabled channel with R>=2:
  - Restart (first enabled edge, sync, or leaving R=0): cnt<=0.
  - Otherwise: cnt<=(cnt==R-1)?0:cnt+1.
- Outputs are registered from the next count: clk_out<=(cnt_next<H), tick<=(cnt_next==0).
  - Result: clk_out is high H cycles and low R-H cycles; tick is coincident with the clk_out rising edge.
- Enable:
  - The first edge with ch_en=1 gives clk_out=1, tick=1 (zero extra latency).
  - ch_en=0 stops the channel on the next edge: cnt=0, clk_out=0, tick=0. The active ratio is retained.
- Ratio load:
  - Running channel: div_load[i] captures the slice into pending and sets pend.
  - Commit: at the edge where cnt wraps R-1->0, the new period uses the pending ratio and pend clears.
  - A load arriving in the wrap cycle itself is not committed at that wrap. It waits one more period.
  - Back-to-back loads before a commit: the last one wins.
- Idle commit: if the channel is disabled, or its active R=0, a load writes the active ratio directly on the next edge and pend stays 0.
- sync=1: every enabled channel with R>=2 restarts. Any pending ratio commits first; pend clears, cnt=0, clk_out=1, tick=1. sync has priority over the wrap and over a same-cycle load; that load goes to pending afterwards.
- Ratio 1: clk_out held at 1 and tick=1 every enabled cycle.
- Ratio 0: channel idle; clk_out=0, tick=0.
- Channels are fully independent except for the shared sync input.

Decomposition:
- Package clk_div_pkg:
  - DIV_W default and DEFAULT_DIV.
  - Function half_hi(R) returning ceil(R/2).
  - Localparam for the ratio slice indexing.
- Sub-module clk_div_chan: one channel (counter, shadow register, output registers). clk_divider_multi instantiates N_CH of them in a generate loop and fans out sync.

Test Plan:
- Reset, then ch_en[0]=1 with default R=10 -> clk_out[0] pattern 5 high/5 low repeating; tick[0] every 10 cycles, on the first enabled edge.
- Load 7 while disabled, then enable -> 4 high/3 low; pend never asserts.
- R=10 running, load 3 at cnt=4:
  - pend=1 from the next edge.
  - The current period finishes all 10 cycles, then the channel runs 2 high/1 low.
  - pend drops at the wrap.
- Load 6 during the wrap cycle of an R=10 channel -> one more full 10-cycle period, then 6.
- ch0 R=4 and ch1 R=6 running out of phase; pulse sync -> both tick in the same cycle. Realignment repeats every 12 cycles.
- Special ratios and reset:
  - R=1 gives clk_out constantly high and tick every cycle.
  - R=0 gives both low.
  - rst asserted mid-period with pend=1 -> all outputs 0 next edge; R=10 and pend=0 afterwards.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DEF_DIV_W = 10;
  localparam int DEF_DIV   = 10;

  // High phase length of a period: ceil(R/2).
  function automatic int unsigned half_hi(input int unsigned r);
    return (r + 1) / 2;
  endfunction

  // Low bit of channel ch's ratio slice within the packed ratio bus.
  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/clk_divider_multi_if.sv
// Control/status bundle of the multi-channel divider.
interface clk_divider_multi_if import clk_div_pkg::*; #(
  parameter int N_CH  = 4,
  parameter int DIV_W = DEF_DIV_W
);
  logic [N_CH-1:0]       ch_en;
  logic [N_CH*DIV_W-1:0] div_ratio;
  logic [N_CH-1:0]       div_load;
  logic                  sync;
  logic [N_CH-1:0]       clk_out;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pend;

  modport master (
    output ch_en, div_ratio, div_load, sync,
    input  clk_out, tick, pend
  );

  modport slave (
    input  ch_en, div_ratio, div_load, sync,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow ratio register and registered outputs.
module clk_div_chan import clk_div_pkg::*; #(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] ratio_in,
  input  logic             load,
  input  logic             sync,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] cnt, r_act, r_pend;
  logic             run;

  logic [DIV_W-1:0] cnt_next, r_next, r_pend_next;
  logic             pend_next, run_next, clk_next, tick_next;
  logic [DIV_W:0]   half;
  logic             restart, wrap;

  always_comb begin
    cnt_next    = '0;
    r_next      = r_act;
    r_pend_next = r_pend;
    pend_next   = pend;
    run_next    = 1'b0;
    clk_next    = 1'b0;
    tick_next   = 1'b0;
    half        = '0;
    restart     = !run || sync;
    wrap        = (cnt == r_act - DIV_W'(1));

    if (!en) begin
      if (load) begin
        r_next    = ratio_in;
        pend_next = 1'b0;
      end
    end else if (r_act == '0) begin
      // Idle channel: a new ratio lands directly; the following edge restarts it.
      if (load)
        r_next = ratio_in;
      else if (pend)
        r_next = r_pend;
      pend_next = 1'b0;
    end else begin
      if (restart || wrap) begin
        if (pend)
          r_next = r_pend;
        pend_next = 1'b0;
      end else begin
        cnt_next = cnt + DIV_W'(1);
      end
      // A load in a commit cycle lands after the commit, so it waits a full period.
      if (load) begin
        r_pend_next = ratio_in;
        pend_next   = 1'b1;
      end
      half      = (DIV_W+1)'(half_hi(32'(r_next)));
      run_next  = (r_next != '0);
      clk_next  = ({1'b0, cnt_next} < half);
      tick_next = run_next && (cnt_next == '0);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt     <= '0;
      r_act   <= DIV_W'(DEFAULT_DIV);
      pend    <= 1'b0;
      run     <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      cnt     <= cnt_next;
      r_act   <= r_next;
      pend    <= pend_next;
      run     <= run_next;
      clk_out <= clk_next;
      tick    <= tick_next;
    end
  end

  // Pending ratio is only meaningful while pend is set.
  always_ff @(posedge clk_in) begin
    r_pend <= r_pend_next;
  end

endmodule

// File: rtl/clk_divider_multi.sv
// N_CH independent programmable clock dividers sharing one phase-align sync input.
module clk_divider_multi import clk_div_pkg::*; #(
  parameter int N_CH        = 4,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic               clk_in,
  input  logic               rst,
  clk_divider_multi_if.slave bus
);

  logic [N_CH-1:0] clk_out_v, tick_v, pend_v;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    localparam int LO = slice_lo(i, DIV_W);

    clk_div_chan #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in   (clk_in),
      .rst      (rst),
      .en       (bus.ch_en[i]),
      .ratio_in (bus.div_ratio[LO +: DIV_W]),
      .load     (bus.div_load[i]),
      .sync     (bus.sync),
      .clk_out  (clk_out_v[i]),
      .tick     (tick_v[i]),
      .pend     (pend_v[i])
    );
  end

  assign bus.clk_out = clk_out_v;
  assign bus.tick    = tick_v;
  assign bus.pend    = pend_v;

endmodule
